// File: rtl/aes_pkg.sv
// Shared AES constants and types: word type, schedule geometry, S-box,
// round constants and the key-expansion state encoding.
package aes_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned NK     = 4;
    localparam int unsigned NR     = 10;
    localparam int unsigned NWORDS = 44;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // RCON[0] is Rcon[1] of the schedule (first word of round key 1)
    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    // Round constant for schedule word idx (only meaningful when idx is a multiple of 4)
    function automatic logic [7:0] rcon_for_idx(input logic [5:0] idx);
        logic [3:0] rnd;
        rnd = idx[5:2];
        if (rnd >= 4'd1 && rnd <= 4'd10) begin
            return RCON[rnd - 4'd1];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: byte-wise AES S-box substitution of one 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    // Four independent S-box lookups, one per byte lane
    always_comb begin
        o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                  SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};
    end

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key expansion: one schedule word per clock, finished
// schedule held stable in DONE until the next accepted Start.
module aes_key_expansion
    import aes_pkg::*;
(
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Start,
    input  logic [127:0]   Cipherkey,
    output logic [1407:0]  KeySchedule,
    output logic           Busy,
    output logic           Done
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_idx;
    logic [5:0]  w_idx_nxt;
    logic        w_load;
    logic        w_write;
    logic        r_busy;
    logic        r_done;
    word_t       r_w [NWORDS];

    logic [5:0]  w_im1;
    logic [5:0]  w_im4;
    word_t       w_prev;
    word_t       w_back4;
    word_t       w_rot;
    word_t       w_sub;
    word_t       w_temp;
    word_t       w_new;

    // Source indices clamped so that IDLE/DONE values of idx never select outside the schedule
    always_comb begin
        w_im1 = (r_idx >= 6'd1) ? (r_idx - 6'd1) : 6'd0;
        w_im4 = (r_idx >= 6'd4) ? (r_idx - 6'd4) : 6'd0;
    end

    assign w_prev  = r_w[w_im1];
    assign w_back4 = r_w[w_im4];
    assign w_rot   = {w_prev[23:0], w_prev[31:24]};

    aes_sub_word u_sub_word (
        .i_word (w_rot),
        .o_word (w_sub)
    );

    // Per-word recurrence: first word of each round key gets RotWord/SubWord/Rcon
    always_comb begin
        w_temp = w_prev;
        if (r_idx[1:0] == 2'b00) begin
            w_temp = w_sub ^ {rcon_for_idx(r_idx), 24'h000000};
        end
        w_new = w_back4 ^ w_temp;
    end

    // Next-state, idx and load/write strobes
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_write     = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (Start) begin
                    w_state_nxt = EXPAND;
                    w_idx_nxt   = 6'd4;
                    w_load      = 1'b1;
                end
            end
            EXPAND: begin
                w_write = 1'b1;
                if (r_idx == 6'(NWORDS - 1)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_idx_nxt = r_idx + 6'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, idx and registered Busy/Done decoded from the next state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_idx   <= 6'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_busy  <= (w_state_nxt == EXPAND);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    // Schedule storage: load the cipher key words, then write one derived word per cycle
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NWORDS; i++) begin
                r_w[i] <= '0;
            end
        end else if (w_load) begin
            for (int unsigned i = 0; i < NK; i++) begin
                r_w[i] <= Cipherkey[127 - 32*i -: 32];
            end
        end else if (w_write) begin
            r_w[r_idx] <= w_new;
        end
    end

    // Flatten the word array: word 0 in the most significant position
    always_comb begin
        KeySchedule = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            KeySchedule[1407 - 32*i -: 32] = r_w[i];
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Scoreboard bench for aes_key_expansion with an independent key-schedule model
// (S-box derived from GF(2^8) inversion plus the affine map).
module tb_aes_key_expansion;

    logic           Clk;
    logic           Reset_n;
    logic           Start;
    logic [127:0]   Cipherkey;
    logic [1407:0]  KeySchedule;
    logic           Busy;
    logic           Done;

    int n_vec;
    int n_err;

    logic [7:0]     sb [256];
    logic [7:0]     rc [11];
    logic [1407:0]  exp_q [$];

    aes_key_expansion dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Cipherkey   (Cipherkey),
        .KeySchedule (KeySchedule),
        .Busy        (Busy),
        .Done        (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int j = 2; j <= 10; j++) rc[j] = xtime(rc[j-1]);
    endtask

    function automatic logic [1407:0] model(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [1407:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc[i/4], 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) s[1407 - 32*i -: 32] = w[i];
        return s;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic chk_sched(input string nm, input logic [1407:0] act, input logic [1407:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            for (int r = 0; r < 11; r++) begin
                if (act[1407 - 128*r -: 128] !== req[1407 - 128*r -: 128]) begin
                    $display("FAIL %s: round key %0d got %h, expected %h", nm, r,
                             act[1407 - 128*r -: 128], req[1407 - 128*r -: 128]);
                    break;
                end
            end
        end
    endtask

    // mode 0: plain, 1: extra Start at cycle 20, 2: key toggles every cycle, 3: reset at cycle 15
    task automatic run_key(input logic [127:0] key, input int mode);
        int cycles;
        @(negedge Clk);
        Start     = 1'b1;
        Cipherkey = key;
        exp_q.push_back(model(key));
        @(posedge Clk);
        #1;
        chk("accept_busy_done", {126'd0, Busy, Done}, 128'd2);
        Start  = 1'b0;
        cycles = 0;
        while (!Done && cycles < 100) begin
            @(negedge Clk);
            Start = (mode == 1 && cycles == 19);
            if (mode == 1 && cycles == 19) Cipherkey = ~key;
            if (mode == 2) Cipherkey = {$urandom, $urandom, $urandom, $urandom};
            if (mode == 3 && cycles == 14) begin
                Reset_n = 1'b0;
                #1;
                chk_sched("abort_sched_zero", KeySchedule, '0);
                chk("abort_busy_done", {126'd0, Busy, Done}, 128'd0);
                void'(exp_q.pop_back());
                #1;
                Reset_n = 1'b1;
                return;
            end
            @(posedge Clk);
            #1;
            cycles++;
            if (Busy && Done) chk("busy_done_exclusive", {126'd0, Busy, Done}, 128'd2);
        end
        chk("done_latency", 128'(cycles), 128'd40);
        if (mode == 2) chk("rk0_is_accepted_key", KeySchedule[1407:1280], key);
    endtask

    // Monitor: on each Done rising edge, pop the expected schedule and compare
    initial begin
        logic          prev_done;
        logic [1407:0] req;
        prev_done = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (Done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", {127'd0, Done}, 128'd0);
                end else begin
                    req = exp_q.pop_front();
                    chk_sched("schedule", KeySchedule, req);
                end
            end
            prev_done = Done;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] k;
        n_vec     = 0;
        n_err     = 0;
        Reset_n   = 1'b0;
        Start     = 1'b0;
        Cipherkey = '0;
        build_tables();
        repeat (3) @(posedge Clk);
        #1;
        chk_sched("reset_sched", KeySchedule, '0);
        chk("reset_busy_done", {126'd0, Busy, Done}, 128'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        run_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        chk("fips_w4", 128'(KeySchedule[1279:1248]), 128'h a0fafe17);
        chk("fips_rk10", KeySchedule[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_key(128'h0, 0);
        chk("zero_w4", 128'(KeySchedule[1279:1248]), 128'h62636363);
        chk("zero_rk10", KeySchedule[127:0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        run_key({$urandom, $urandom, $urandom, $urandom}, 1);
        run_key({$urandom, $urandom, $urandom, $urandom}, 3);
        @(negedge Clk);
        chk("post_abort_idle", {126'd0, Busy, Done}, 128'd0);
        run_key({$urandom, $urandom, $urandom, $urandom}, 0);
        run_key({$urandom, $urandom, $urandom, $urandom}, 2);
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            run_key(k, 0);
        end
        repeat (5) @(posedge Clk);
        #2;
        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
